game_flow_ctrl: RTL and testbench



---
 rtl/game_flow_ctrl.sv | 133 +++++++++++++
 tb/tb_game_flow_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Overworld/battle game sequencer: title -> roam -> battle loop over the elite
// battles, frame-paced fades between modes, and registered mode enables.
module game_flow_ctrl #(
    parameter int          NUM_BATTLES = 5,
    parameter logic [5:0]  FADE_FRAMES = 6'd30,
    parameter logic [7:0]  ENTER       = 8'h28
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       start_battle,
    input  logic       battle_win,
    input  logic       battle_lose,
    output logic       is_title,
    output logic       is_roam,
    output logic       is_battle,
    output logic       is_fade,
    output logic [5:0] fade_level,
    output logic [2:0] cur_battle,
    output logic       game_won,
    output logic       game_lost
);

    typedef enum logic [2:0] {
        S_TITLE,
        S_ROAM,
        S_FADE_TO_BATTLE,
        S_BATTLE,
        S_FADE_TO_ROAM,
        S_VICTORY,
        S_DEFEAT
    } state_t;

    localparam logic [2:0] LAST_BATTLE = 3'(NUM_BATTLES - 1);
    localparam logic [5:0] LAST_STEP   = FADE_FRAMES - 6'd1;

    state_t     state, state_nxt;
    logic [5:0] fade_cnt, fade_nxt;
    logic [2:0] battle_nxt;
    logic       frame_d, frame_edge;
    logic       key_armed;
    logic       enter_press;
    logic       fade_nxt_active;

    // A held ENTER fires once: the key must be seen released before it re-arms.
    assign enter_press     = (keycode == ENTER) && key_armed;
    assign fade_nxt_active = (state_nxt == S_FADE_TO_BATTLE) || (state_nxt == S_FADE_TO_ROAM);

    // NOTE: every variable gets a default first so the decode cannot infer a latch.
    always_comb begin
        state_nxt  = state;
        fade_nxt   = fade_cnt;
        battle_nxt = cur_battle;
        case (state)
            S_TITLE: begin
                if (enter_press) state_nxt = S_ROAM;
            end
            S_ROAM: begin
                if (start_battle) begin
                    state_nxt = S_FADE_TO_BATTLE;
                    fade_nxt  = 6'd0;
                end
            end
            S_FADE_TO_BATTLE, S_FADE_TO_ROAM: begin
                if (frame_edge) begin
                    if (fade_cnt == LAST_STEP) begin
                        state_nxt = (state == S_FADE_TO_BATTLE) ? S_BATTLE : S_ROAM;
                        fade_nxt  = 6'd0;
                    end else begin
                        fade_nxt = fade_cnt + 6'd1;
                    end
                end
            end
            S_BATTLE: begin
                // A loss outranks a simultaneous win.
                if (battle_lose) begin
                    state_nxt = S_DEFEAT;
                end else if (battle_win) begin
                    if (cur_battle == LAST_BATTLE) begin
                        state_nxt = S_VICTORY;
                    end else begin
                        state_nxt  = S_FADE_TO_ROAM;
                        battle_nxt = cur_battle + 3'd1;
                        fade_nxt   = 6'd0;
                    end
                end
            end
            S_VICTORY, S_DEFEAT: begin
                if (enter_press) begin
                    state_nxt  = S_TITLE;
                    battle_nxt = 3'd0;
                end
            end
            default: state_nxt = S_TITLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_TITLE;
            fade_cnt   <= 6'd0;
            cur_battle <= 3'd0;
            key_armed  <= 1'b0;
            frame_d    <= 1'b0;
            frame_edge <= 1'b0;
            is_title   <= 1'b1;
            is_roam    <= 1'b0;
            is_battle  <= 1'b0;
            is_fade    <= 1'b0;
            fade_level <= 6'd0;
            game_won   <= 1'b0;
            game_lost  <= 1'b0;
        end else begin
            state      <= state_nxt;
            fade_cnt   <= fade_nxt;
            cur_battle <= battle_nxt;
            key_armed  <= (keycode != ENTER);
            frame_d    <= frame_clk;
            frame_edge <= frame_clk & ~frame_d;
            is_title   <= (state_nxt == S_TITLE);
            is_roam    <= (state_nxt == S_ROAM);
            is_battle  <= (state_nxt == S_BATTLE);
            is_fade    <= fade_nxt_active;
            fade_level <= fade_nxt_active ? fade_nxt : 6'd0;
            game_won   <= (state_nxt == S_VICTORY);
            game_lost  <= (state_nxt == S_DEFEAT);
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: a behavioural model queues the expected
// outputs for each driven cycle; they are popped and compared after the edge.
module tb_game_flow_ctrl;

    localparam logic [7:0] ENTER = 8'h28;
    localparam int         NFADE = 30;

    typedef enum int {M_TITLE, M_ROAM, M_FTB, M_BATTLE, M_FTR, M_VICTORY, M_DEFEAT} mstate_t;

    typedef struct {
        logic [5:0] mode;   // {title, roam, battle, fade, won, lost}
        logic [5:0] level;
        logic [2:0] batt;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       start_battle = 1'b0;
    logic       battle_win = 1'b0;
    logic       battle_lose = 1'b0;
    logic       is_title, is_roam, is_battle, is_fade, game_won, game_lost;
    logic [5:0] fade_level;
    logic [2:0] cur_battle;

    game_flow_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .start_battle(start_battle), .battle_win(battle_win), .battle_lose(battle_lose),
        .is_title(is_title), .is_roam(is_roam), .is_battle(is_battle), .is_fade(is_fade),
        .fade_level(fade_level), .cur_battle(cur_battle),
        .game_won(game_won), .game_lost(game_lost)
    );

    always #5 Clk = ~Clk;

    int      n_checks = 0;
    int      n_fail   = 0;
    int      cycle    = 0;
    exp_t    sb_q[$];

    mstate_t m_state = M_TITLE;
    int      m_fade  = 0;
    int      m_batt  = 0;
    logic    m_armed = 1'b0;
    logic    m_fd    = 1'b0;
    logic    m_fe    = 1'b0;
    logic    fclk    = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cycle, got, exp);
        end
    endtask

    // Drive one cycle, advance the model, queue its prediction, then compare after the edge.
    task automatic step(input logic rst, input logic [7:0] key, input logic sb,
                        input logic win, input logic lose, input logic fc);
        logic press;
        logic in_fade;
        exp_t e, got;
        Reset = rst; keycode = key; start_battle = sb;
        battle_win = win; battle_lose = lose; frame_clk = fc;
        if (rst) begin
            m_state = M_TITLE; m_fade = 0; m_batt = 0;
            m_armed = 1'b0; m_fd = 1'b0; m_fe = 1'b0;
        end else begin
            press = (key == ENTER) && m_armed;
            case (m_state)
                M_TITLE: if (press) m_state = M_ROAM;
                M_ROAM:  if (sb) begin m_state = M_FTB; m_fade = 0; end
                M_FTB, M_FTR: if (m_fe) begin
                    if (m_fade == NFADE - 1) begin
                        m_state = (m_state == M_FTB) ? M_BATTLE : M_ROAM;
                        m_fade  = 0;
                    end else m_fade++;
                end
                M_BATTLE: begin
                    if (lose) m_state = M_DEFEAT;
                    else if (win && m_batt == 4) m_state = M_VICTORY;
                    else if (win) begin m_batt++; m_state = M_FTR; m_fade = 0; end
                end
                default: if (press) begin m_state = M_TITLE; m_batt = 0; end
            endcase
            m_armed = (key != ENTER);
            m_fe    = fc & ~m_fd;
            m_fd    = fc;
        end
        in_fade = (m_state == M_FTB) || (m_state == M_FTR);
        e.mode  = {m_state == M_TITLE, m_state == M_ROAM, m_state == M_BATTLE,
                   in_fade, m_state == M_VICTORY, m_state == M_DEFEAT};
        e.level = in_fade ? 6'(m_fade) : 6'd0;
        e.batt  = 3'(m_batt);
        sb_q.push_back(e);
        @(posedge Clk);
        @(negedge Clk);
        cycle++;
        got = sb_q.pop_front();
        check("mode", int'({is_title, is_roam, is_battle, is_fade, game_won, game_lost}), int'(got.mode));
        check("fade_level", int'(fade_level), int'(got.level));
        check("cur_battle", int'(cur_battle), int'(got.batt));
    endtask

    task automatic idle(input logic [7:0] key);
        step(1'b0, key, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Toggle frame_clk every cycle until the model leaves the fade (bounded).
    task automatic run_fade(input logic [7:0] key);
        int guard = 0;
        while ((m_state == M_FTB || m_state == M_FTR) && guard < 400) begin
            fclk = ~fclk;
            step(1'b0, key, 1'b0, 1'b0, 1'b0, fclk);
            guard++;
        end
        fclk = 1'b0;
    endtask

    task automatic win_round(input logic [7:0] key);
        step(1'b0, key, 1'b0, 1'b1, 1'b0, 1'b0);
        run_fade(key);
        step(1'b0, key, 1'b1, 1'b0, 1'b0, 1'b0);
        run_fade(key);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge Clk);
        // ENTER held through reset must not advance; release then press enters roam.
        step(1'b1, ENTER, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, ENTER, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) idle(ENTER);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(ENTER);
        // Stray battle results and keys in roam are ignored.
        step(1'b0, ENTER, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(8'h04);
        // First battle, then four wins; ENTER held through the last approach.
        step(1'b0, ENTER, 1'b1, 1'b0, 1'b0, 1'b0);
        run_fade(ENTER);
        for (int r = 0; r < 3; r++) win_round(8'h00);
        win_round(ENTER);
        step(1'b0, ENTER, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, ENTER, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(ENTER);
        idle(8'h00);
        idle(ENTER);
        // Defeat with simultaneous win and lose at cur_battle = 2.
        idle(8'h00);
        idle(ENTER);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        run_fade(8'h00);
        win_round(8'h00);
        win_round(8'h00);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(ENTER);
        idle(8'h00);
        idle(ENTER);
        // Reset partway through a fade to battle.
        idle(8'h00);
        idle(ENTER);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 200 && !(m_state == M_FTB && m_fade == 12); g++) begin
            fclk = ~fclk;
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, fclk);
        end
        fclk = 1'b0;
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8'h00);
        idle(ENTER);
        idle(8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
